// File: rtl/fft_control.sv
// rtl/fft_control.sv - sequencing FSM for a 1024-point, 10-stage in-place FFT
//
// Loads 1024 samples into the butterfly RAM through the external write port.
// It then steps the address generator through 10 stages of 512 butterflies.
// Finally it streams the results out by RAM read address.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   startFFT                  begin a transform (honoured only while idle)
//   in_valid/in_ready         input sample handshake
//   in_real/in_imag           signed input sample
//   externalLoad              RAM external write strobe
//   externalIndexA            RAM external write address
//   external_real_A/_imag_A   RAM external write data
//   load                      butterfly write-back enable
//   stageCount/cycleCount     stage 0..9 and butterfly 0..511 to the address generator
//   out_valid/out_ready       result handshake
//   out_index                 RAM read address of the offered result
//   busy                      high whenever a transform is in progress
//   done                      one-cycle pulse after the last result is taken
module fft_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        startFFT,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_real,
  input  logic [31:0] in_imag,
  output logic        externalLoad,
  output logic [9:0]  externalIndexA,
  output logic [31:0] external_real_A,
  output logic [31:0] external_imag_A,
  output logic        load,
  output logic [4:0]  stageCount,
  output logic [8:0]  cycleCount,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_index,
  output logic        busy,
  output logic        done
);

  localparam logic [9:0] LAST_POINT     = 10'd1023;
  localparam logic [8:0] LAST_BUTTERFLY = 9'd511;
  localparam logic [4:0] LAST_STAGE     = 5'd9;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, UNLOAD} state_t;

  state_t     state;
  logic [9:0] sample_cnt;
  logic [9:0] result_cnt;
  logic       in_load;

  assign in_load  = (state == LOAD);
  assign in_ready = in_load;

  // The write port is a straight pass-through of the input stream while loading.
  // It is forced to zero otherwise so the RAM never sees stray addresses or data.
  assign externalLoad    = in_load && in_valid;
  assign externalIndexA  = in_load ? sample_cnt : 10'd0;
  assign external_real_A = in_load ? in_real : 32'd0;
  assign external_imag_A = in_load ? in_imag : 32'd0;

  // result_cnt wraps back to zero on the final accept.
  // The read address therefore idles at zero without an extra clear.
  assign out_index = result_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= 10'd0;
      result_cnt <= 10'd0;
      stageCount <= 5'd0;
      cycleCount <= 9'd0;
      load       <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startFFT) begin
            state      <= LOAD;
            sample_cnt <= 10'd0;
            busy       <= 1'b1;
          end
        end

        LOAD: begin
          if (in_valid) begin
            sample_cnt <= sample_cnt + 10'd1;  // wraps to 0 after the last point
            if (sample_cnt == LAST_POINT) begin
              state      <= CALC;
              load       <= 1'b1;
              stageCount <= 5'd0;
              cycleCount <= 9'd0;
            end
          end
        end

        CALC: begin
          if (cycleCount == LAST_BUTTERFLY) begin
            cycleCount <= 9'd0;
            if (stageCount == LAST_STAGE) begin
              state      <= UNLOAD;
              load       <= 1'b0;
              stageCount <= 5'd0;
              out_valid  <= 1'b1;
              result_cnt <= 10'd0;
            end else begin
              stageCount <= stageCount + 5'd1;
            end
          end else begin
            cycleCount <= cycleCount + 9'd1;
          end
        end

        UNLOAD: begin
          if (out_ready) begin
            result_cnt <= result_cnt + 10'd1;
            if (result_cnt == LAST_POINT) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_control.sv
// tb/tb_fft_control.sv - self-checking bench for fft_control
module tb_fft_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        startFFT;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_real;
  logic [31:0] in_imag;
  logic        externalLoad;
  logic [9:0]  externalIndexA;
  logic [31:0] external_real_A;
  logic [31:0] external_imag_A;
  logic        load;
  logic [4:0]  stageCount;
  logic [8:0]  cycleCount;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_index;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  fft_control dut (
    .clk             (clk),
    .rst             (rst),
    .startFFT        (startFFT),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_real         (in_real),
    .in_imag         (in_imag),
    .externalLoad    (externalLoad),
    .externalIndexA  (externalIndexA),
    .external_real_A (external_real_A),
    .external_imag_A (external_imag_A),
    .load            (load),
    .stageCount      (stageCount),
    .cycleCount      (cycleCount),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_index       (out_index),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [103:0] obs_v();
    return {in_ready, externalLoad, externalIndexA, external_real_A, external_imag_A,
            load, stageCount, cycleCount, out_valid, out_index, busy, done};
  endfunction

  task automatic test_reset();
    rst = 1'b1; startFFT = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_real = 32'd0; in_imag = 32'd0;
    repeat (2) tick();
    total++;
    if (obs_v() !== 104'd0)
      $display("FAIL reset_values got=%h want=%h", obs_v(), 104'd0);
    if (obs_v() !== 104'd0) bad++;
    rst = 1'b0; startFFT = 1'b0;
    tick();
    total++;
    if ({busy, in_ready} !== 2'b00) begin
      bad++;
      $display("FAIL start_with_reset busy,in_ready got=%b want=00", {busy, in_ready});
    end
  endtask

  // Reference: phase is implied by how many input beats, butterfly cycles
  // and output beats the model has counted, never by DUT state.
  task automatic test_full_run(input string tag);
    int n_in, n_calc, n_out, cyc, load_cycles;
    logic iv, orr, e_load, e_calc, e_unl;
    logic [31:0] re, im;
    logic [103:0] exp_v;
    startFFT = 1'b1; tick(); startFFT = 1'b0;
    n_in = 0; n_calc = 0; n_out = 0; cyc = 0; load_cycles = 0;
    while (n_out < 1024 && cyc < 20000) begin
      iv  = ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      re  = iv ? $urandom : 32'd0;
      im  = iv ? $urandom : 32'd0;
      in_valid = iv; out_ready = orr; in_real = re; in_imag = im;
      startFFT = ($urandom_range(0, 15) == 0);
      #1;
      e_load = (n_in < 1024);
      e_calc = !e_load && (n_calc < 5120);
      e_unl  = !e_load && !e_calc;
      exp_v = {e_load, e_load && iv, e_load ? 10'(n_in) : 10'd0,
               e_load ? re : 32'd0, e_load ? im : 32'd0,
               e_calc, e_calc ? 5'(n_calc / 512) : 5'd0, e_calc ? 9'(n_calc % 512) : 9'd0,
               e_unl, e_unl ? 10'(n_out) : 10'd0, 1'b1, 1'b0};
      total++;
      if (obs_v() !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs_v(), exp_v);
      end
      if (load) load_cycles++;
      @(posedge clk);
      if (e_load) begin
        if (iv) n_in++;
      end else if (e_calc) begin
        n_calc++;
      end else if (orr) begin
        n_out++;
      end
      #1;
      cyc++;
    end
    startFFT = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (n_out !== 1024 || load_cycles !== 5120) begin
      bad++;
      $display("FAIL %s_length outs=%0d load_cycles=%0d want 1024/5120", tag, n_out, load_cycles);
    end
    total++;
    if ({done, busy, out_valid, load} !== 4'b1000) begin
      bad++;
      $display("FAIL %s_done done,busy,out_valid,load got=%b want=1000", tag, {done, busy, out_valid, load});
    end
    tick();
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++;
      $display("FAIL %s_done_pulse done,busy got=%b want=00", tag, {done, busy});
    end
  endtask

  task automatic test_input_stall();
    int errs;
    errs = 0;
    startFFT = 1'b1; tick(); startFFT = 1'b0;
    for (int b = 0; b < 1024; b++) begin
      in_valid = 1'b1; in_real = 32'(b); in_imag = ~32'(b);
      #1;
      if (externalLoad !== 1'b1 || externalIndexA !== 10'(b) ||
          external_real_A !== 32'(b) || external_imag_A !== ~32'(b)) errs++;
      if (b == 101) begin
        total++;
        if (externalIndexA !== 10'd101) begin
          bad++;
          $display("FAIL stall_resume index got=%0d want=101", externalIndexA);
        end
      end
      tick();
      if (b == 100) begin
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          total++;
          if ({externalLoad, externalIndexA, in_ready} !== {1'b0, 10'd101, 1'b1}) begin
            bad++;
            $display("FAIL stall_hold load,index,ready got=%b/%0d/%b want=0/101/1",
                     externalLoad, externalIndexA, in_ready);
          end
          tick();
        end
      end
    end
    in_valid = 1'b0; in_real = 32'd0; in_imag = 32'd0;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL load_sequence bad_beats got=%0d want=0", errs);
    end
    #1;
    total++;
    if ({in_ready, load, stageCount, cycleCount} !== {1'b0, 1'b1, 5'd0, 9'd0}) begin
      bad++;
      $display("FAIL calc_entry ready,load,stage,cycle got=%b/%b/%0d/%0d want=0/1/0/0",
               in_ready, load, stageCount, cycleCount);
    end
  endtask

  // Continues from the first CALC cycle left by test_input_stall.
  task automatic test_stage_boundary();
    repeat (511) tick();
    total++;
    if ({stageCount, cycleCount} !== {5'd0, 9'd511}) begin
      bad++;
      $display("FAIL stage0_end stage,cycle got=%0d/%0d want=0/511", stageCount, cycleCount);
    end
    tick();
    total++;
    if ({stageCount, cycleCount, load} !== {5'd1, 9'd0, 1'b1}) begin
      bad++;
      $display("FAIL stage1_start stage,cycle,load got=%0d/%0d/%b want=1/0/1", stageCount, cycleCount, load);
    end
    repeat (5119 - 512) tick();
    total++;
    if ({stageCount, cycleCount, load, out_valid} !== {5'd9, 9'd511, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL last_butterfly stage,cycle,load,ov got=%0d/%0d/%b/%b want=9/511/1/0",
               stageCount, cycleCount, load, out_valid);
    end
    tick();
    total++;
    if ({out_valid, load, stageCount, cycleCount, out_index} !== {1'b1, 1'b0, 5'd0, 9'd0, 10'd0}) begin
      bad++;
      $display("FAIL unload_entry ov,load,stage,cycle,idx got=%b/%b/%0d/%0d/%0d want=1/0/0/0/0",
               out_valid, load, stageCount, cycleCount, out_index);
    end
  endtask

  // Continues from the first UNLOAD cycle left by test_stage_boundary.
  task automatic test_backpressure();
    int k;
    out_ready = 1'b1;
    repeat (512) tick();
    total++;
    if (out_index !== 10'd512) begin
      bad++;
      $display("FAIL unload_progress index got=%0d want=512", out_index);
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      total++;
      if ({out_index, out_valid, done} !== {10'd512, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL backpressure_hold idx,ov,done got=%0d/%b/%b want=512/1/0", out_index, out_valid, done);
      end
    end
    out_ready = 1'b1;
    k = 0;
    while (done !== 1'b1 && k < 600) begin
      tick();
      k++;
    end
    total++;
    if (k !== 512) begin
      bad++;
      $display("FAIL done_latency accepts got=%0d want=512", k);
    end
    out_ready = 1'b0;
    tick();
    total++;
    if ({done, busy, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL done_single done,busy,ov got=%b want=000", {done, busy, out_valid});
    end
  endtask

  task automatic test_reset_mid_calc();
    int k;
    startFFT = 1'b1; tick(); startFFT = 1'b0;
    in_valid = 1'b1;
    repeat (1024) tick();
    in_valid = 1'b0;
    k = 0;
    while (stageCount !== 5'd4 && k < 3000) begin
      tick();
      k++;
    end
    total++;
    if (stageCount !== 5'd4) begin
      bad++;
      $display("FAIL reach_stage4 stage got=%0d want=4", stageCount);
    end
    repeat (37) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, load, stageCount, cycleCount, in_ready, out_valid, done} !== 19'd0) begin
      bad++;
      $display("FAIL mid_calc_reset busy,load,stage,cycle got=%b/%b/%0d/%0d want=0/0/0/0",
               busy, load, stageCount, cycleCount);
    end
    repeat (3) tick();
    total++;
    if (obs_v() !== 104'd0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=0", obs_v());
    end
  endtask

  initial begin
    test_reset();
    test_full_run("full_run");
    test_input_stall();
    test_stage_boundary();
    test_backpressure();
    test_reset_mid_calc();
    test_full_run("rerun");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_control.md
FFT_CONTROL -- requirements
Module: fft_control

Interface
REQ-001 SHALL have no parameters; transform size fixed at 1024 points, 10 stages, 512 butterflies per stage.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 startFFT  input  1  request a new transform; sampled only in IDLE.
REQ-006 in_valid / in_ready  input / output  1 / 1  sample-stream handshake.
REQ-007 in_real / in_imag  input  32 / 32  signed sample, real and imaginary.
REQ-008 externalLoad  output  1  RAM external-write strobe.
REQ-009 externalIndexA  output  10  RAM external write address.
REQ-010 external_real_A / external_imag_A  output  32 / 32  RAM external write data.
REQ-011 load  output  1  butterfly write-back enable to RAM.
REQ-012 stageCount  output  5  current stage to address generator, 0..9.
REQ-013 cycleCount  output  9  current butterfly index to address generator, 0..511.
REQ-014 out_valid / out_ready  output / input  1 / 1  result-stream handshake.
REQ-015 out_index  output  10  RAM read address of the current result; data is taken combinationally from RAM port A by the consumer.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the last result is accepted.

Function
REQ-018 SHALL implement four states: IDLE, LOAD, CALC, UNLOAD.
REQ-019 IDLE: in_ready=0, load=0, externalLoad=0, out_valid=0; startFFT=1 -> LOAD next cycle, sample counter cleared to 0.
REQ-020 LOAD: in_ready=1 combinationally; on each cycle with in_valid=1, externalLoad=1, externalIndexA=sample counter, external_real_A/imag_A = in_real/in_imag (same cycle, no register).
REQ-021 LOAD: in_valid=0 -> externalLoad=0, counter holds (stall of any length allowed).
REQ-022 LOAD: beat with counter=1023 -> CALC next cycle with stageCount=0, cycleCount=0; counter wraps to 0.
REQ-023 CALC: load=1 every cycle; cycleCount increments by 1 per cycle; at cycleCount=511 it wraps to 0 and stageCount increments.
REQ-024 CALC: at stageCount=9 and cycleCount=511 -> UNLOAD next cycle; CALC lasts exactly 5120 cycles; no stalls.
REQ-025 UNLOAD: out_valid=1, out_index=result counter starting at 0; counter advances only when out_valid and out_ready both 1.
REQ-026 UNLOAD: accepted beat at out_index=1023 -> done=1 that cycle... registered: done=1 for exactly one cycle following the accepting edge, state IDLE, out_valid=0.
REQ-027 externalLoad and load SHALL never be high in the same cycle.
REQ-028 startFFT while busy=1 SHALL be ignored (no restart, no queueing).
REQ-029 When not in LOAD, externalIndexA and external data SHALL be 0; when not in CALC, stageCount and cycleCount SHALL be 0.

Reset
REQ-030 rst=1 at any posedge (including mid-LOAD/CALC/UNLOAD) SHALL force IDLE and clear all counters next cycle.
REQ-031 Reset values: in_ready=0, externalLoad=0, externalIndexA=0, external data=0, load=0, stageCount=0, cycleCount=0, out_valid=0, out_index=0, busy=0, done=0.
REQ-032 A startFFT coincident with rst=1 SHALL be ignored.

Verification
REQ-033 Full run: startFFT, 1024 beats in_valid=1 with in_real=index -> externalIndexA 0..1023 matches, CALC starts, load high 5120 cycles, stageCount reaches 9, out_index 0..1023, single done pulse.
REQ-034 Input stall: drop in_valid for 3 cycles after beat 100 -> externalLoad=0 those cycles, next write lands at externalIndexA=101.
REQ-035 Output backpressure: out_ready=0 for 5 cycles at out_index=512 -> out_index holds 512, out_valid stays 1, no done.
REQ-036 Stage boundary: at CALC cycle 511 -> next cycle stageCount=1, cycleCount=0; after stage 9 cycle 511 -> out_valid=1.
REQ-037 Reset mid-CALC (stageCount=4) -> next cycle IDLE, load=0, stageCount=0, busy=0; a new startFFT runs a complete transform.
REQ-038 startFFT pulsed during CALC and UNLOAD -> no effect; exactly one done pulse observed.
